icache_refill_ctrl: RTL

//  Write-side engine for the instruction-cache data RAM (32-bit simple dual-port, 1024 words).
//  On a miss it fetches one cache line from external memory as a single burst.
//  It writes each returned word into the RAM write port and pulses a tag-update/done strobe.
//  It sits between the icache lookup logic (miss source) and the memory fabric.

---
 rtl/icache_refill_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill engine: fetches one line per miss as a single burst and writes it into the data RAM.
// Define ICACHE_REFILL_CWF_EN to request the missing word first, with the burst wrapping inside the line.
module icache_refill_ctrl #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int LINE_WORDS     = 8,
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     miss_req,
    input  logic [MEM_ADDR_WIDTH-1:0]                miss_addr,
    output logic                                     busy,
    output logic                                     mem_req,
    output logic [MEM_ADDR_WIDTH-1:0]                mem_addr,
    input  logic                                     mem_gnt,
    input  logic                                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]                    mem_rdata,
    input  logic                                     mem_err,
    output logic                                     wr_en,
    output logic [ADDR_WIDTH-1:0]                    wr_addr,
    output logic [DATA_WIDTH-1:0]                    wr_data,
    output logic                                     tag_wr_en,
    output logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0] tag_idx,
    output logic                                     refill_done,
    output logic                                     refill_err
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = ADDR_WIDTH - OFF_W;
    localparam logic [OFF_W-1:0]          LAST_CNT  = OFF_W'(LINE_WORDS - 1);
    localparam logic [OFF_W-1:0]          CNT_ONE   = OFF_W'(1);
    localparam logic [MEM_ADDR_WIDTH-1:0] LINE_MASK = MEM_ADDR_WIDTH'((1 << (OFF_W + 2)) - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] WORD_MASK = MEM_ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [IDX_W-1:0]          r_line_idx;
    logic [OFF_W-1:0]          r_start_off;
    logic [OFF_W-1:0]          r_cnt;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic                      r_wr_en;
    logic [ADDR_WIDTH-1:0]     r_wr_addr;
    logic [DATA_WIDTH-1:0]     r_wr_data;
    logic                      r_err;

    logic                      w_accept;
    logic                      w_beat_ok;
    logic                      w_beat_err;
    logic                      w_last;
    logic [OFF_W-1:0]          w_beat_off;
    logic [OFF_W-1:0]          w_start_off;
    logic [MEM_ADDR_WIDTH-1:0] w_req_addr;

`ifdef ICACHE_REFILL_CWF_EN
    assign w_start_off = miss_addr[OFF_W+1:2];
    assign w_req_addr  = miss_addr & ~WORD_MASK;
`else
    assign w_start_off = '0;
    assign w_req_addr  = miss_addr & ~LINE_MASK;
`endif

    assign w_accept   = miss_req && (r_state == S_IDLE);
    // Beats outside FILL (including any before the grant) are deliberately dropped.
    assign w_beat_ok  = (r_state == S_FILL) && mem_rvalid && !mem_err;
    assign w_beat_err = (r_state == S_FILL) && mem_rvalid && mem_err;
    assign w_last     = (r_cnt == LAST_CNT);
    assign w_beat_off = r_start_off + r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        mem_req      = 1'b0;
        tag_wr_en    = 1'b0;
        refill_done  = 1'b0;
        refill_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (miss_req) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_gnt) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                busy = 1'b1;
                if (w_beat_err || (w_beat_ok && w_last)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                refill_done  = 1'b1;
                refill_err   = r_err;
                tag_wr_en    = !r_err;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_idx  <= '0;
            r_start_off <= '0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_wr_en <= w_beat_ok;
            if (w_accept) begin
                r_line_idx  <= miss_addr[ADDR_WIDTH+1:OFF_W+2];
                r_start_off <= w_start_off;
                r_mem_addr  <= w_req_addr;
                r_cnt       <= '0;
                r_err       <= 1'b0;
            end
            if (w_beat_ok) begin
                // Offset wraps inside the line; the line index is concatenated, never added.
                r_wr_addr <= {r_line_idx, w_beat_off};
                r_wr_data <= mem_rdata;
                r_cnt     <= r_cnt + CNT_ONE;
            end
            if (w_beat_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_addr = r_mem_addr;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign tag_idx  = r_line_idx;

endmodule
